// File: rtl/alu4_top_if.sv
// alu4_top_if: operand/opcode/result bundle for the 4-bit ALU.
// The master drives operands and opcode; the slave (the ALU) returns result and carry.
interface alu4_top_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] opcode;
    logic [7:0] result;
    logic       carry;

    modport master (
        output A,
        output B,
        output opcode,
        input  result,
        input  carry
    );

    modport slave (
        input  A,
        input  B,
        input  opcode,
        output result,
        output carry
    );
endinterface

// File: rtl/alu4_top.sv
// alu4_top: 4-bit unsigned ALU with registered 8-bit result and carry/flag bit.
// Operations: add, subtract, multiply, divide, OR, AND, rotate-by-one, compare.
// Build option: define ALU_DIV_EN to build the divider; without it opcode 011
// returns result 8'h00 and carry 0.
module alu4_top (
    input logic        clk,
    input logic        rst_n,
    alu4_top_if.slave  bus
);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpMul = 3'b010,
        OpDiv = 3'b011,
        OpOr  = 3'b100,
        OpAnd = 3'b101,
        OpRot = 3'b110,
        OpCmp = 3'b111
    } op_e;

    op_e        op;
    logic [4:0] add_sum;
    logic [4:0] sub_diff;
    logic [7:0] mul_prod;
    logic [3:0] rot_val;
    logic       rot_carry;
    logic [2:0] cmp_flags;
    logic [7:0] div_result;
    logic       div_carry;

    logic [7:0] result_d, result_q;
    logic       carry_d, carry_q;

    assign op = op_e'(bus.opcode);

    // Arithmetic units: 5-bit add/sub expose carry and borrow in bit 4.
    always_comb begin
        add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
        sub_diff = {1'b0, bus.A} - {1'b0, bus.B};
        mul_prod = {4'b0000, bus.A} * {4'b0000, bus.B};
    end

    // Rotate by one bit; B[3] picks direction, the bit that wraps is reported as carry.
    always_comb begin
        if (bus.B[3]) begin
            rot_val   = {bus.A[0], bus.A[3:1]};
            rot_carry = bus.A[0];
        end else begin
            rot_val   = {bus.A[2:0], bus.A[3]};
            rot_carry = bus.A[3];
        end
    end

    // Compare flags {gt, eq, lt}; exactly one is set.
    always_comb begin
        cmp_flags[2] = (bus.A > bus.B);
        cmp_flags[1] = (bus.A == bus.B);
        cmp_flags[0] = (bus.A < bus.B);
    end

`ifdef ALU_DIV_EN
    logic [3:0] div_quot;
    logic [4:0] div_part;
    logic       div_by_zero;

    // Restoring division, one quotient bit per step from the MSB down.
    // The partial remainder needs 5 bits because it is shifted before the compare.
    always_comb begin
        div_part = 5'd0;
        div_quot = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            div_part = {div_part[3:0], bus.A[i]};
            if (div_part >= {1'b0, bus.B}) begin
                div_part    = div_part - {1'b0, bus.B};
                div_quot[i] = 1'b1;
            end
        end
    end

    // Divide-by-zero overrides the divider output with the error pattern.
    always_comb begin
        div_by_zero = (bus.B == 4'd0);
        if (div_by_zero) begin
            div_result = 8'hFF;
            div_carry  = 1'b1;
        end else begin
            div_result = {div_part[3:0], div_quot};
            div_carry  = 1'b0;
        end
    end
`else
    // Divider not built: opcode 011 reads as zero.
    always_comb begin
        div_result = 8'h00;
        div_carry  = 1'b0;
    end
`endif

    // Opcode decode selecting the next registered result and carry.
    always_comb begin
        result_d = 8'h00;
        carry_d  = 1'b0;
        unique case (op)
            OpAdd: begin
                result_d = {4'b0000, add_sum[3:0]};
                carry_d  = add_sum[4];
            end
            OpSub: begin
                result_d = {4'b0000, sub_diff[3:0]};
                carry_d  = sub_diff[4];
            end
            OpMul: begin
                result_d = mul_prod;
            end
            OpDiv: begin
                result_d = div_result;
                carry_d  = div_carry;
            end
            OpOr: begin
                result_d = {4'b0000, bus.A | bus.B};
            end
            OpAnd: begin
                result_d = {4'b0000, bus.A & bus.B};
            end
            OpRot: begin
                result_d = {4'b0000, rot_val};
                carry_d  = rot_carry;
            end
            OpCmp: begin
                result_d = {5'b00000, cmp_flags};
            end
            default: begin
                result_d = 8'h00;
                carry_d  = 1'b0;
            end
        endcase
    end

    // Output register; asynchronous reset clears any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 8'h00;
            carry_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;

endmodule

// File: tb/tb_alu4_top.sv
// tb_alu4_top: directed vector table, randomized checks against a reference
// model, and reset/latency corner sequences for alu4_top.
module tb_alu4_top;

    logic clk;
    logic rst_n;

    alu4_top_if bus ();

    alu4_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       c;
    } vec_t;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour computed from the operation rules with integer arithmetic.
    function automatic logic [8:0] model(input int a, input int b, input int op);
        int   r;
        logic c;
        r = 0;
        c = 1'b0;
        case (op)
            0: begin r = (a + b) % 16; c = ((a + b) > 15); end
            1: begin r = (a - b + 16) % 16; c = (a < b); end
            2: r = a * b;
`ifdef ALU_DIV_EN
            3: begin
                if (b == 0) begin r = 255; c = 1'b1; end
                else r = (a % b) * 16 + a / b;
            end
`else
            3: r = 0;
`endif
            4: r = a | b;
            5: r = a & b;
            6: begin
                if (b >= 8) begin r = a / 2 + (a % 2) * 8; c = (a % 2 == 1); end
                else begin r = (a * 2) % 16 + a / 8; c = (a >= 8); end
            end
            default: r = (a < b) ? 1 : ((a == b) ? 2 : 4);
        endcase
        return {c, 8'(r)};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got carry=%b result=0x%02h, expected carry=%b result=0x%02h",
                     name, act[8], act[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        @(negedge clk);
        bus.A      = a;
        bus.B      = b;
        bus.opcode = op;
    endtask

    initial begin
        vec_t vecs[$];
        logic [8:0] prev;
        logic [8:0] exp;

        checks = 0;
        errors = 0;

        vecs.push_back('{4'd5,    4'd12,   3'b000, 8'h01, 1'b1});
        vecs.push_back('{4'd15,   4'd15,   3'b000, 8'h0E, 1'b1});
        vecs.push_back('{4'd9,    4'd4,    3'b001, 8'h05, 1'b0});
        vecs.push_back('{4'd9,    4'd2,    3'b001, 8'h07, 1'b0});
        vecs.push_back('{4'd2,    4'd9,    3'b001, 8'h09, 1'b1});
        vecs.push_back('{4'd6,    4'd3,    3'b010, 8'h12, 1'b0});
        vecs.push_back('{4'd15,   4'd15,   3'b010, 8'hE1, 1'b0});
`ifdef ALU_DIV_EN
        vecs.push_back('{4'd8,    4'd2,    3'b011, 8'h04, 1'b0});
        vecs.push_back('{4'd7,    4'd2,    3'b011, 8'h13, 1'b0});
        vecs.push_back('{4'd7,    4'd0,    3'b011, 8'hFF, 1'b1});
        vecs.push_back('{4'd15,   4'd4,    3'b011, 8'h33, 1'b0});
`else
        vecs.push_back('{4'd8,    4'd2,    3'b011, 8'h00, 1'b0});
        vecs.push_back('{4'd7,    4'd0,    3'b011, 8'h00, 1'b0});
`endif
        vecs.push_back('{4'b1100, 4'b1010, 3'b100, 8'h0E, 1'b0});
        vecs.push_back('{4'b1011, 4'b0000, 3'b101, 8'h00, 1'b0});
        vecs.push_back('{4'b1010, 4'b0001, 3'b110, 8'h05, 1'b1});
        vecs.push_back('{4'b1001, 4'b0000, 3'b110, 8'h03, 1'b1});
        vecs.push_back('{4'b1001, 4'b1000, 3'b110, 8'h0C, 1'b1});
        vecs.push_back('{4'b0110, 4'b1111, 3'b110, 8'h03, 1'b0});
        vecs.push_back('{4'd6,    4'd8,    3'b111, 8'h01, 1'b0});
        vecs.push_back('{4'd10,   4'd10,   3'b111, 8'h02, 1'b0});
        vecs.push_back('{4'd9,    4'd3,    3'b111, 8'h04, 1'b0});

        // Reset asserted from time zero: outputs clear before any clock edge.
        rst_n      = 1'b0;
        bus.A      = 4'd15;
        bus.B      = 4'd15;
        bus.opcode = 3'b010;
        #1;
        check("reset_no_clock", {bus.carry, bus.result}, 9'h000);
        @(posedge clk);
        #1;
        check("reset_hold_edge", {bus.carry, bus.result}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, one vector per cycle (back-to-back opcode changes).
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_op%0d_a%0d_b%0d", i, vecs[i].op, vecs[i].a, vecs[i].b),
                  {bus.carry, bus.result}, {vecs[i].c, vecs[i].res});
        end

        // Randomized operations; also verify the output holds until the next edge.
        prev = model(vecs[vecs.size() - 1].a, vecs[vecs.size() - 1].b,
                     vecs[vecs.size() - 1].op);
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [2:0] rop;
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 3'($urandom_range(0, 7));
            exp = model(ra, rb, rop);
            drive(ra, rb, rop);
            #1;
            if (i % 8 == 0) check($sformatf("hold%0d", i), {bus.carry, bus.result}, prev);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_op%0d_a%0d_b%0d", i, rop, ra, rb),
                  {bus.carry, bus.result}, exp);
            prev = exp;
        end

        // Mid-stream reset discards the registered value asynchronously.
        drive(4'd15, 4'd15, 3'b010);
        @(posedge clk);
        #1;
        check("pre_reset_mul", {bus.carry, bus.result}, 9'h0E1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", {bus.carry, bus.result}, 9'h000);
        @(posedge clk);
        #1;
        check("reset_hold_mid", {bus.carry, bus.result}, 9'h000);
        drive(4'd5, 4'd12, 3'b000);
        rst_n = 1'b1;
        #1;
        check("post_release_no_edge", {bus.carry, bus.result}, 9'h000);
        @(posedge clk);
        #1;
        check("first_capture_after_release", {bus.carry, bus.result}, 9'h101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
